// File: rtl/relu_forward_layer.sv
// Streaming forward ReLU / leaky-ReLU over WIDTH fp32 lanes with a one-deep output register.
// Define RELU_FWD_MASK_FIFO_EN to build the activation-mask FIFO consumed by the backward layer.

module relu_fwd_lane #(
  parameter int NEG_SHIFT = 0
) (
  input  logic [31:0] i_x,
  output logic [31:0] o_y,
  output logic        o_mask
);
  localparam logic [7:0] SH = 8'(NEG_SHIFT);

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_nan;

  assign w_sign = i_x[31];
  assign w_exp  = i_x[30:23];
  assign w_man  = i_x[22:0];
  assign w_nan  = (w_exp == 8'hFF) && (w_man != '0);

  // Leaky slope is a power of two, so scaling is an exponent decrement; underflow flushes to -0.0.
  always_comb begin
    o_y    = i_x;
    o_mask = 1'b0;
    if (w_nan)                  o_y    = i_x;
    else if (!w_sign)           o_mask = |i_x[30:0];
    else if (NEG_SHIFT == 0)    o_y    = '0;
    else if (w_exp == 8'hFF)    o_y    = i_x;
    else if (w_exp > SH)        o_y    = {1'b1, w_exp - SH, w_man};
    else                        o_y    = 32'h8000_0000;
  end
endmodule

module relu_forward_layer #(
  parameter int WIDTH      = 4,
  parameter int NEG_SHIFT  = 0,
  parameter int MASK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0][31:0]       in_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0][31:0]       out_vec,
  input  logic                         mask_rd,
  output logic                         mask_valid,
  output logic [WIDTH-1:0]             mask_out,
  output logic [$clog2(MASK_DEPTH):0]  mask_count
);
  logic [WIDTH-1:0][31:0] w_relu;
  logic [WIDTH-1:0]       w_mask;
  logic                   w_accept;
  logic                   w_mask_full;
  logic                   r_out_valid;
  logic [WIDTH-1:0][31:0] r_out_vec;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    relu_fwd_lane #(.NEG_SHIFT(NEG_SHIFT)) u_lane (
      .i_x    (in_vec[g]),
      .o_y    (w_relu[g]),
      .o_mask (w_mask[g])
    );
  end

  assign in_ready = (!r_out_valid || out_ready) && !w_mask_full;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_vec   <= w_relu;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_vec   = r_out_vec;

`ifdef RELU_FWD_MASK_FIFO_EN
  localparam int         AW    = $clog2(MASK_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(MASK_DEPTH);

  logic [MASK_DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]                    r_wr_ptr;
  logic [AW-1:0]                    r_rd_ptr;
  logic [AW:0]                      r_count;
  logic                             w_pop;

  // No read-to-write bypass when full: a pop frees space only from the next cycle on.
  assign w_mask_full = (r_count == DEPTH);
  assign w_pop       = mask_rd && (r_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_mask;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign mask_valid = (r_count != '0);
  assign mask_out   = r_mem[r_rd_ptr];
  assign mask_count = r_count;
`else
  logic w_unused;

  assign w_unused    = mask_rd ^ (|w_mask);
  assign w_mask_full = 1'b0;
  assign mask_valid  = 1'b0;
  assign mask_out    = '0;
  assign mask_count  = '0;
`endif
endmodule

// File: tb/tb_relu_forward_layer.sv
// Scoreboard bench: two instances (plain ReLU and leaky shift 2) share stimulus; a spec-level model predicts outputs.
module tb_relu_forward_layer;
  localparam int W     = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset, in_valid, out_ready, mask_rd;
  logic [W-1:0][31:0] in_vec;
  logic rdy0, rdy2, ov0, ov2, mv0, mv2;
  logic [W-1:0][31:0] ovec0, ovec2;
  logic [W-1:0] mo0, mo2;
  logic [$clog2(DEPTH):0] mc0, mc2;

  always #5 clk = ~clk;

  relu_forward_layer #(.WIDTH(W), .NEG_SHIFT(0), .MASK_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_vec(in_vec),
    .out_valid(ov0), .out_ready(out_ready), .out_vec(ovec0), .mask_rd(mask_rd),
    .mask_valid(mv0), .mask_out(mo0), .mask_count(mc0));

  relu_forward_layer #(.WIDTH(W), .NEG_SHIFT(2), .MASK_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_vec(in_vec),
    .out_valid(ov2), .out_ready(out_ready), .out_vec(ovec2), .mask_rd(mask_rd),
    .mask_valid(mv2), .mask_out(mo2), .mask_count(mc2));

  int n_vec = 0, n_err = 0, n_chk = 0;
  logic [W-1:0][31:0] q0[$], q2[$];
  logic [W-1:0]       qm[$];
  bit exp_ov = 1'b0;
  int exp_cnt = 0;
  bit m_acc, m_pop, exp_rdy;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: DUT presented output with empty scoreboard", nm);
  endtask

  // Element rule from the spec: returns {mask_bit, result}.
  function automatic logic [32:0] ref_elem(input logic [31:0] x, input int ns);
    int e;
    e = int'(x[30:23]);
    if (e == 255 && x[22:0] != 0) return {1'b0, x};
    if (!x[31])                   return {(x[30:0] != 0), x};
    if (ns == 0)                  return {1'b0, 32'h0};
    if (e == 255)                 return {1'b0, x};
    if (e > ns)                   return {1'b0, 1'b1, 8'(e - ns), x[22:0]};
    return {1'b0, 32'h8000_0000};
  endfunction

  function automatic logic [W-1:0][31:0] ref_vec(input logic [W-1:0][31:0] v, input int ns);
    logic [32:0] t;
    for (int i = 0; i < W; i++) begin
      t = ref_elem(v[i], ns);
      ref_vec[i] = t[31:0];
    end
  endfunction

  function automatic logic [W-1:0] ref_mask(input logic [W-1:0][31:0] v);
    logic [32:0] t;
    for (int i = 0; i < W; i++) begin
      t = ref_elem(v[i], 0);
      ref_mask[i] = t[32];
    end
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0:       return {r[31], 8'd0, r[22:0]};
      1:       return {r[31], 8'hFF, 23'd0};
      2:       return {r[31], 8'hFF, r[22:1], 1'b1};
      3:       return {1'b1, 5'd0, r[25:23], r[22:0]};
      4:       return {r[31], 31'd0};
      default: return r;
    endcase
  endfunction

  function automatic logic [W-1:0][31:0] rnd_vec();
    for (int i = 0; i < W; i++) rnd_vec[i] = rnd_f();
  endfunction

  function automatic bit model_rdy();
`ifdef RELU_FWD_MASK_FIFO_EN
    return (!exp_ov || out_ready) && (exp_cnt < DEPTH);
`else
    return !exp_ov || out_ready;
`endif
  endfunction

  // Reference model: advances the expected state on every clock edge.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      q0.delete(); q2.delete(); qm.delete();
      exp_ov  = 1'b0;
      exp_cnt = 0;
    end else begin
      m_acc = in_valid && model_rdy();
`ifdef RELU_FWD_MASK_FIFO_EN
      m_pop = mask_rd && (exp_cnt > 0);
`else
      m_pop = 1'b0;
`endif
      if (m_acc) begin
        n_vec++;
        q0.push_back(ref_vec(in_vec, 0));
        q2.push_back(ref_vec(in_vec, 2));
`ifdef RELU_FWD_MASK_FIFO_EN
        qm.push_back(ref_mask(in_vec));
`endif
      end
      exp_cnt = exp_cnt + int'(m_acc) - int'(m_pop);
      exp_ov  = m_acc ? 1'b1 : (out_ready ? 1'b0 : exp_ov);
    end
  end

  // Monitor: compares on the falling edge, pops on handshakes that the next rising edge completes.
  initial forever begin
    @(negedge clk);
    exp_rdy = model_rdy();
    chk("in_ready0", rdy0, exp_rdy);
    chk("in_ready2", rdy2, exp_rdy);
    chk("out_valid0", ov0, exp_ov);
    chk("out_valid2", ov2, exp_ov);
    if (ov0) begin
      if (q0.size() == 0) fail("out_vec0");
      else begin
        chk("out_vec0", ovec0, q0[0]);
        if (out_ready) void'(q0.pop_front());
      end
    end
    if (ov2) begin
      if (q2.size() == 0) fail("out_vec2");
      else begin
        chk("out_vec2", ovec2, q2[0]);
        if (out_ready) void'(q2.pop_front());
      end
    end
`ifdef RELU_FWD_MASK_FIFO_EN
    chk("mask_count0", mc0, exp_cnt);
    chk("mask_count2", mc2, exp_cnt);
    chk("mask_valid0", mv0, exp_cnt != 0);
    if (mv0) begin
      if (qm.size() == 0) fail("mask_out");
      else begin
        chk("mask_out0", mo0, qm[0]);
        chk("mask_out2", mo2, qm[0]);
        if (mask_rd) void'(qm.pop_front());
      end
    end
`else
    chk("mask_valid_off", mv0 | mv2, 0);
    chk("mask_count_off", mc0 | mc2, 0);
    chk("mask_out_off", mo0 | mo2, 0);
`endif
  end

  task automatic send(input logic [W-1:0][31:0] v, input int budget, output bit ok);
    in_valid = 1'b1;
    in_vec   = v;
    ok       = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = rdy0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_masks();
    mask_rd = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mc0 == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mask_rd = 1'b0;
    chk("drain", mc0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nacc;
    logic [W-1:0][31:0] v;
    reset = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1; mask_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); chk("reset_in_ready", rdy0, 1);
    @(posedge clk); #1;

    v = {32'h7FC00000, 32'h80000000, 32'hBF800000, 32'h3F800000};
    send(v, 4, ok); chk("send_a", ok, 1);
    @(negedge clk);
    chk("relu_a", ovec0, {32'h7FC00000, 32'h00000000, 32'h00000000, 32'h3F800000});
`ifdef RELU_FWD_MASK_FIFO_EN
    chk("mask_a", mo0, 4'b0001);
`endif
    @(posedge clk); #1;
    v = {32'h40400000, 32'hFF800000, 32'h80800000, 32'hC0000000};
    send(v, 4, ok); chk("send_b", ok, 1);
    @(negedge clk);
    chk("leaky_b", ovec2, {32'h40400000, 32'hFF800000, 32'h80000000, 32'hBF000000});
    @(posedge clk); #1;
`ifdef RELU_FWD_MASK_FIFO_EN
    mask_rd = 1'b1;
    @(posedge clk); #1 mask_rd = 1'b0;
    @(negedge clk); chk("mask_b", mo0, 4'b1000);
    @(posedge clk); #1;
    drain_masks();
`endif

    out_ready = 1'b0; in_valid = 1'b1; in_vec = rnd_vec(); nacc = 0;
    repeat (3) begin
      @(negedge clk); if (rdy0) nacc++;
      @(posedge clk); #1;
    end
    chk("bp_one_accept", nacc, 1);
    @(negedge clk); chk("bp_blocked", rdy0, 0);
    @(posedge clk); #1;
    out_ready = 1'b1; in_vec = rnd_vec();
    @(negedge clk); chk("bp_release", rdy0, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;

`ifdef RELU_FWD_MASK_FIFO_EN
    drain_masks();
    for (int i = 0; i < DEPTH; i++) begin
      send(rnd_vec(), 3, ok); chk("fill", ok, 1);
    end
    in_valid = 1'b1; in_vec = rnd_vec();
    @(negedge clk); chk("full_count", mc0, 8); chk("full_block", rdy0, 0);
    @(posedge clk); #1 mask_rd = 1'b1;
    @(negedge clk); chk("full_nobypass", rdy0, 0);
    @(posedge clk); #1 mask_rd = 1'b0;
    @(negedge clk); chk("pop_count", mc0, 7); chk("resume", rdy0, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("refill_count", mc0, 8);
    @(posedge clk); #1;
    drain_masks();
`else
    in_valid = 1'b1; nacc = 0;
    for (int i = 0; i < 20; i++) begin
      in_vec = rnd_vec();
      @(negedge clk); if (rdy0) nacc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_20", nacc, 20);
`endif

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 2) != 0;
      in_vec    = rnd_vec();
      out_ready = ($urandom % 4) != 0;
      mask_rd   = ($urandom % 3) == 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; mask_rd = 1'b0;
`ifdef RELU_FWD_MASK_FIFO_EN
    drain_masks();
`else
    repeat (2) begin @(posedge clk); #1; end
`endif

    for (int i = 0; i < 3; i++) begin
      send(rnd_vec(), 3, ok); chk("pre_rst_send", ok, 1);
    end
    out_ready = 1'b0;
    @(negedge clk); chk("pre_rst_ov", ov0, 1);
`ifdef RELU_FWD_MASK_FIFO_EN
    chk("pre_rst_cnt", mc0, 3);
`endif
    #2 reset = 1'b0;
    #1;
    chk("rst_ov", {ov0, ov2}, 2'b00);
    chk("rst_vec0", ovec0, 0);
    chk("rst_vec2", ovec2, 0);
    chk("rst_cnt", mc0, 0);
    chk("rst_mv", mv0, 0);
    chk("rst_mo", mo0, 0);
    @(posedge clk); #1 reset = 1'b1; out_ready = 1'b1;
    @(negedge clk); chk("post_rst_ready", rdy0, 1);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
